// File: rtl/lvg_sequencer_pkg.sv
// Shared opcode values, FSM state encoding and opcode classifier for the lvg instruction sequencer.
package lvg_sequencer_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDA  = 8'h01;
  localparam logic [7:0] OP_LDB  = 8'h02;
  localparam logic [7:0] OP_LDC  = 8'h03;
  localparam logic [7:0] OP_ST   = 8'h04;
  localparam logic [7:0] OP_MM0  = 8'h05;
  localparam logic [7:0] OP_MM1  = 8'h06;
  localparam logic [7:0] OP_MM2  = 8'h07;
  localparam logic [7:0] OP_MM3  = 8'h08;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_MEM, ST_EXEC, ST_HALT, ST_ERR
  } seq_state_e;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_LD, CLS_ST, CLS_CMP, CLS_HALT, CLS_ILL
  } op_class_e;

  function automatic op_class_e decode_op(input logic [7:0] op);
    op_class_e cls;
    case (op)
      OP_NOP:                       cls = CLS_NOP;
      OP_LDA, OP_LDB, OP_LDC:       cls = CLS_LD;
      OP_ST:                        cls = CLS_ST;
      OP_MM0, OP_MM1, OP_MM2, OP_MM3: cls = CLS_CMP;
      OP_HALT:                      cls = CLS_HALT;
      default:                      cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/lvg_sequencer_watchdog.sv
// EXEC watchdog: reloads to zero on load, counts while count is high, flags expiry on the
// TIMEOUT-th counted cycle.
module lvg_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = count && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (count && !expire)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lvg_sequencer.sv
// Instruction sequencer for the lvg systolic engine: fetch/decode FSM driving weight-memory
// strobes and a start/done handshake. Optional EXEC watchdog enabled by LVG_SEQ_TIMEOUT_EN.
module lvg_sequencer
  import lvg_sequencer_pkg::*;
#(
  parameter int AW      = 8,
  parameter int WAW     = 8,
  parameter int MEM_LAT = 1,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  output logic [AW-1:0]  instr_addr,
  input  logic [15:0]    instr_data,
  output logic [WAW-1:0] wmem_addr,
  output logic           wmem_rd,
  output logic           wmem_wr,
  output logic [7:0]     lvg_op,
  output logic           lvg_start,
  input  logic           lvg_done,
  output logic           busy,
  output logic           halted,
  output logic           err
);

  if (MEM_LAT < 1) begin : g_bad_mem_lat
    $error("MEM_LAT must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  localparam int MCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [MCW-1:0] MEM_CNT_INIT = MCW'(MEM_LAT - 1);

  seq_state_e     state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [AW-1:0]  instr_addr_q, instr_addr_d;
  logic [WAW-1:0] wmem_addr_q, wmem_addr_d;
  logic           wmem_rd_q, wmem_rd_d;
  logic           wmem_wr_q, wmem_wr_d;
  logic [7:0]     lvg_op_q, lvg_op_d;
  logic           lvg_start_q, lvg_start_d;
  logic           busy_q, busy_d;
  logic           halted_q, halted_d;
  logic           err_q, err_d;
  logic [MCW-1:0] mem_cnt_q, mem_cnt_d;
  op_class_e      op_cls;

  assign op_cls = decode_op(instr_data[7:0]);

`ifdef LVG_SEQ_TIMEOUT_EN
  logic wd_expire;
  lvg_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .load   ((state_q == ST_DECODE) && (op_cls == CLS_CMP)),
    .count  (state_q == ST_EXEC),
    .expire (wd_expire)
  );
`else
  logic wd_expire;
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_addr_d = instr_addr_q;
    wmem_addr_d  = wmem_addr_q;
    wmem_rd_d    = 1'b0;
    wmem_wr_d    = 1'b0;
    lvg_op_d     = lvg_op_q;
    lvg_start_d  = 1'b0;
    halted_d     = halted_q;
    err_d        = err_q;
    mem_cnt_d    = mem_cnt_q;
    case (state_q)
      ST_IDLE, ST_HALT, ST_ERR: begin
        if (go) begin
          state_d  = ST_FETCH;
          pc_d     = '0;
          halted_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      ST_FETCH: begin
        instr_addr_d = pc_q;
        state_d      = ST_DECODE;
      end
      ST_DECODE: begin
        pc_d     = pc_q + 1'b1;
        lvg_op_d = instr_data[7:0];
        case (op_cls)
          CLS_NOP: state_d = ST_FETCH;
          CLS_LD, CLS_ST: begin
            wmem_addr_d = WAW'(instr_data[15:8]);
            wmem_rd_d   = (op_cls == CLS_LD);
            wmem_wr_d   = (op_cls == CLS_ST);
            mem_cnt_d   = MEM_CNT_INIT;
            state_d     = ST_MEM;
          end
          CLS_CMP: begin
            lvg_start_d = 1'b1;
            state_d     = ST_EXEC;
          end
          CLS_HALT: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        endcase
      end
      ST_MEM: begin
        // The strobe cycle is the first of the MEM_LAT wait cycles.
        if (mem_cnt_q == '0)
          state_d = ST_FETCH;
        else
          mem_cnt_d = mem_cnt_q - 1'b1;
      end
      ST_EXEC: begin
        // A done coinciding with our own start pulse belongs to an earlier op.
        if (lvg_done && !lvg_start_q) begin
          state_d = ST_FETCH;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_FETCH) || (state_d == ST_DECODE) ||
             (state_d == ST_MEM)   || (state_d == ST_EXEC);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      instr_addr_q <= '0;
      wmem_addr_q  <= '0;
      wmem_rd_q    <= 1'b0;
      wmem_wr_q    <= 1'b0;
      lvg_op_q     <= '0;
      lvg_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
      mem_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_addr_q <= instr_addr_d;
      wmem_addr_q  <= wmem_addr_d;
      wmem_rd_q    <= wmem_rd_d;
      wmem_wr_q    <= wmem_wr_d;
      lvg_op_q     <= lvg_op_d;
      lvg_start_q  <= lvg_start_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      err_q        <= err_d;
      mem_cnt_q    <= mem_cnt_d;
    end
  end

  assign instr_addr = instr_addr_q;
  assign wmem_addr  = wmem_addr_q;
  assign wmem_rd    = wmem_rd_q;
  assign wmem_wr    = wmem_wr_q;
  assign lvg_op     = lvg_op_q;
  assign lvg_start  = lvg_start_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lvg_sequencer.sv
// Directed bench for lvg_sequencer (AW=2, MEM_LAT=1, TIMEOUT=8); the watchdog scenario is
// selected by LVG_SEQ_TIMEOUT_EN.
module tb_lvg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic [1:0]  instr_addr;
  logic [15:0] instr_data;
  logic [7:0]  wmem_addr;
  logic        wmem_rd, wmem_wr;
  logic [7:0]  lvg_op;
  logic        lvg_start;
  logic        lvg_done = 1'b0;
  logic        busy, halted, err;

  logic [15:0] imem [0:3];
  int          checks = 0;
  int          passed = 0;

  assign instr_data = imem[instr_addr];

  always #5 clk = ~clk;

  lvg_sequencer #(.AW(2), .WAW(8), .MEM_LAT(1), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .wmem_addr  (wmem_addr),
    .wmem_rd    (wmem_rd),
    .wmem_wr    (wmem_wr),
    .lvg_op     (lvg_op),
    .lvg_start  (lvg_start),
    .lvg_done   (lvg_done),
    .busy       (busy),
    .halted     (halted),
    .err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; go = 1'b0; lvg_done = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  // After return the bench sits in cycle 1 (FETCH) of the program.
  task automatic start_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic test_reset();
    int strobes = 0;
    logic [23:0] outs;
    rst = 1'b0;
    tick(); tick(); tick();
    outs = {instr_addr, wmem_addr, wmem_rd, wmem_wr, lvg_op, lvg_start, busy, halted, err};
    checks++;
    if (outs !== 24'h0) $display("FAIL reset_state outputs=%h expected=%h", outs, 24'h0);
    else passed++;
    rst = 1'b1;
    imem[0] = 16'h0005; imem[1] = 16'h00FF; imem[2] = 16'h0000; imem[3] = 16'h0000;
    start_go();
    for (int c = 2; c <= 4; c++) tick();
    checks++;
    if ({busy, lvg_op} !== {1'b1, 8'h05}) $display("FAIL pre_reset_exec busy,op=%h expected=%h", {busy, lvg_op}, {1'b1, 8'h05});
    else passed++;
    rst = 1'b0;
    tick();
    outs = {instr_addr, wmem_addr, wmem_rd, wmem_wr, lvg_op, lvg_start, busy, halted, err};
    checks++;
    if (outs !== 24'h0) $display("FAIL reset_mid_exec_first outputs=%h expected=%h", outs, 24'h0);
    else passed++;
    tick(); tick();
    outs = {instr_addr, wmem_addr, wmem_rd, wmem_wr, lvg_op, lvg_start, busy, halted, err};
    checks++;
    if (outs !== 24'h0) $display("FAIL reset_mid_exec_held outputs=%h expected=%h", outs, 24'h0);
    else passed++;
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (wmem_rd || wmem_wr || lvg_start || busy) strobes++;
    end
    checks++;
    if (strobes !== 0) $display("FAIL idle_after_reset active_cycles=%0d expected=0", strobes);
    else passed++;
    $display("test_reset: reset held 3 cycles mid-EXEC, idle for 6 cycles after release");
  endtask

  task automatic test_ld_st();
    int rd_n = 0, wr_n = 0, st_n = 0, rd_c = 0, wr_c = 0, h_c = 0, multi = 0;
    logic [7:0] rd_a = '0, wr_a = '0;
    do_reset();
    imem[0] = 16'h1001; imem[1] = 16'h2004; imem[2] = 16'hFFFF; imem[3] = 16'h0000;
    start_go();
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      if (wmem_rd) begin rd_n++; rd_c = c; rd_a = wmem_addr; end
      if (wmem_wr) begin wr_n++; wr_c = c; wr_a = wmem_addr; end
      if (lvg_start) st_n++;
      if ((32'(wmem_rd) + 32'(wmem_wr) + 32'(lvg_start)) > 1) multi++;
      if (halted && h_c == 0) h_c = c;
    end
    checks++;
    if ({rd_n, rd_c} !== {32'd1, 32'd3}) $display("FAIL ld_strobe count=%0d cycle=%0d expected count=1 cycle=3", rd_n, rd_c);
    else passed++;
    checks++;
    if (rd_a !== 8'h10) $display("FAIL ld_addr got=%h expected=10", rd_a);
    else passed++;
    checks++;
    if ({wr_n, wr_c} !== {32'd1, 32'd6}) $display("FAIL st_strobe count=%0d cycle=%0d expected count=1 cycle=6", wr_n, wr_c);
    else passed++;
    checks++;
    if (wr_a !== 8'h20) $display("FAIL st_addr got=%h expected=20", wr_a);
    else passed++;
    checks++;
    if ({st_n, multi} !== {32'd0, 32'd0}) $display("FAIL ld_st_no_start starts=%0d overlaps=%0d expected 0 0", st_n, multi);
    else passed++;
    checks++;
    if ({h_c, 31'd0, busy} !== {32'd9, 32'd0}) $display("FAIL ld_st_halt cycle=%0d busy=%b expected cycle=9 busy=0", h_c, busy);
    else passed++;
    $display("test_ld_st: LD 0x10 then ST 0x20 then HALT");
  endtask

  task automatic test_compute();
    int st_n = 0, st_c = 0, h_c = 0;
    logic [7:0] st_op = '0;
    logic busy4 = 1'b0;
    do_reset();
    imem[0] = 16'h0005; imem[1] = 16'h00FF; imem[2] = 16'h0000; imem[3] = 16'h0000;
    start_go();
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) tick();
      if (lvg_start) begin st_n++; st_c = c; st_op = lvg_op; end
      if (halted && h_c == 0) h_c = c;
      if (c == 4) busy4 = busy;
      // Done in the start cycle (3) must be ignored; the real done arrives 4 cycles later.
      lvg_done = (c == 3) || (c == 7);
    end
    lvg_done = 1'b0;
    checks++;
    if ({st_n, st_c} !== {32'd1, 32'd3}) $display("FAIL compute_start count=%0d cycle=%0d expected count=1 cycle=3", st_n, st_c);
    else passed++;
    checks++;
    if (st_op !== 8'h05) $display("FAIL compute_op got=%h expected=05", st_op);
    else passed++;
    checks++;
    if (busy4 !== 1'b1) $display("FAIL done_in_start_ignored busy=%b expected=1", busy4);
    else passed++;
    checks++;
    if (h_c !== 10) $display("FAIL compute_halt cycle=%0d expected=10", h_c);
    else passed++;
    $display("test_compute: op 0x05 launched once, done after 4 cycles, HALT");
  endtask

  task automatic test_illegal();
    int e_c = 0, strobes = 0, h_c = 0;
    logic err1 = 1'b1;
    logic [1:0] a2 = 2'd3, a4 = 2'd0;
    do_reset();
    imem[0] = 16'h0009; imem[1] = 16'h0000; imem[2] = 16'h0000; imem[3] = 16'h0000;
    start_go();
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      if (err && e_c == 0) e_c = c;
      if (wmem_rd || wmem_wr || lvg_start) strobes++;
    end
    checks++;
    if ({e_c, 31'd0, busy} !== {32'd3, 32'd0}) $display("FAIL illegal_err cycle=%0d busy=%b expected cycle=3 busy=0", e_c, busy);
    else passed++;
    checks++;
    if (strobes !== 0) $display("FAIL illegal_no_strobe strobes=%0d expected=0", strobes);
    else passed++;
    imem[0] = 16'h0000; imem[1] = 16'h00FF;
    start_go();
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      if (c == 1) err1 = err;
      if (c == 2) a2 = instr_addr;
      if (c == 4) a4 = instr_addr;
      if (halted && h_c == 0) h_c = c;
    end
    checks++;
    if (err1 !== 1'b0) $display("FAIL go_clears_err err=%b expected=0", err1);
    else passed++;
    checks++;
    if ({a2, a4, h_c} !== {2'd0, 2'd1, 32'd5}) $display("FAIL refetch addr2=%0d addr4=%0d halt=%0d expected 0 1 5", a2, a4, h_c);
    else passed++;
    $display("test_illegal: opcode 0x09 -> error, go restarts from address 0");
  endtask

  task automatic test_wrap();
    logic [1:0] exp_addr [6];
    logic [1:0] got_addr [6];
    exp_addr[0] = 2'd0; exp_addr[1] = 2'd1; exp_addr[2] = 2'd2;
    exp_addr[3] = 2'd3; exp_addr[4] = 2'd0; exp_addr[5] = 2'd1;
    do_reset();
    for (int i = 0; i < 4; i++) imem[i] = 16'h0000;
    start_go();
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      if (c % 2 == 0) got_addr[c/2 - 1] = instr_addr;
      if (c == 5) go = 1'b1;
      if (c == 8) go = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i]) $display("FAIL wrap_addr[%0d] got=%0d expected=%0d", i, got_addr[i], exp_addr[i]);
      else passed++;
    end
    checks++;
    if ({busy, err, halted} !== 3'b100) $display("FAIL wrap_busy busy,err,halted=%b expected=100", {busy, err, halted});
    else passed++;
    $display("test_wrap: NOP stream wraps 0,1,2,3,0,1 with go ignored while busy");
  endtask

`ifdef LVG_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int e_c = 0, h_c = 0;
    logic err_seen = 1'b0;
    do_reset();
    imem[0] = 16'h0006; imem[1] = 16'h00FF; imem[2] = 16'h0000; imem[3] = 16'h0000;
    start_go();
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) tick();
      if (err && e_c == 0) e_c = c;
    end
    checks++;
    if ({e_c, 31'd0, busy} !== {32'd11, 32'd0}) $display("FAIL timeout_err cycle=%0d busy=%b expected cycle=11 busy=0", e_c, busy);
    else passed++;
    start_go();
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) tick();
      if (err) err_seen = 1'b1;
      if (halted && h_c == 0) h_c = c;
      lvg_done = (c == 10);
    end
    lvg_done = 1'b0;
    checks++;
    if ({err_seen, h_c} !== {1'b0, 32'd13}) $display("FAIL timeout_done_wins err=%b halt=%0d expected err=0 halt=13", err_seen, h_c);
    else passed++;
    $display("test_timeout: watchdog expires after 8 EXEC cycles, done on 8th cycle wins");
  endtask
`else
  task automatic test_timeout();
    int idle_c = 0;
    do_reset();
    imem[0] = 16'h0006; imem[1] = 16'h00FF; imem[2] = 16'h0000; imem[3] = 16'h0000;
    start_go();
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) tick();
      if (!busy || err) idle_c++;
    end
    checks++;
    if (idle_c !== 0) $display("FAIL exec_waits not_busy_or_err_cycles=%0d expected=0", idle_c);
    else passed++;
    $display("test_timeout: without watchdog EXEC waits for done indefinitely");
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) imem[i] = 16'h0000;
    test_reset();
    test_ld_st();
    test_compute();
    test_illegal();
    test_wrap();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
